// File: rtl/key_debounce.sv
// Two-key push-button conditioner: synchronises the raw active-low pins, debounces them,
// and emits a clean level plus single-cycle press/release/long-press pulses per key.
module key_debounce #(
    parameter logic [25:0] CNT_DEB  = 26'd1000000,
    parameter logic [25:0] CNT_LONG = 26'd50000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] key_in,
    output logic [1:0] key_out,
    output logic [1:0] key_press,
    output logic [1:0] key_release,
    output logic [1:0] key_long
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t      state_q [2];
    state_t      state_d [2];
    logic [25:0] dcnt_q  [2];
    logic [25:0] dcnt_d  [2];
    logic [25:0] lcnt_q  [2];
    logic [25:0] lcnt_d  [2];

    logic [1:0] sync1_q, sync2_q;
    logic [1:0] long_done_q, long_done_d;
    logic [1:0] key_out_q, key_out_d;
    logic [1:0] press_q, press_d;
    logic [1:0] release_q, release_d;
    logic [1:0] long_q, long_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            long_done_q <= 2'b00;
            key_out_q   <= 2'b11;
            press_q     <= 2'b00;
            release_q   <= 2'b00;
            long_q      <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                dcnt_q[i]  <= '0;
                lcnt_q[i]  <= '0;
            end
        end else begin
            sync1_q     <= key_in;
            sync2_q     <= sync1_q;
            long_done_q <= long_done_d;
            key_out_q   <= key_out_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
                lcnt_q[i]  <= lcnt_d[i];
            end
        end
    end

    always_comb begin
        long_done_d = long_done_q;
        key_out_d   = key_out_q;
        press_d     = 2'b00;
        release_d   = 2'b00;
        long_d      = 2'b00;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            lcnt_d[i]  = lcnt_q[i];
        end

        for (int i = 0; i < 2; i++) begin
            case (state_q[i])
                IDLE: begin
                    key_out_d[i] = 1'b1;
                    if (!sync2_q[i]) begin
                        state_d[i] = PRESS_DB;
                        dcnt_d[i]  = '0;
                    end
                end
                PRESS_DB: begin
                    if (sync2_q[i]) begin
                        state_d[i] = IDLE;
                        dcnt_d[i]  = '0;
                    end else if (dcnt_q[i] == CNT_DEB - 26'd1) begin
                        state_d[i]     = PRESSED;
                        key_out_d[i]   = 1'b0;
                        press_d[i]     = 1'b1;
                        lcnt_d[i]      = '0;
                        long_done_d[i] = 1'b0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + 26'd1;
                    end
                end
                PRESSED: begin
                    if (sync2_q[i]) begin
                        state_d[i] = RELEASE_DB;
                        dcnt_d[i]  = '0;
                    end else if (!long_done_q[i]) begin
                        if (lcnt_q[i] == CNT_LONG - 26'd1) begin
                            long_d[i]      = 1'b1;
                            long_done_d[i] = 1'b1;
                        end else begin
                            lcnt_d[i] = lcnt_q[i] + 26'd1;
                        end
                    end
                end
                RELEASE_DB: begin
                    // A bounce back to pressed keeps lcnt/long_done so it cannot re-arm long-press.
                    if (!sync2_q[i]) begin
                        state_d[i] = PRESSED;
                        dcnt_d[i]  = '0;
                    end else if (dcnt_q[i] == CNT_DEB - 26'd1) begin
                        state_d[i]   = IDLE;
                        key_out_d[i] = 1'b1;
                        release_d[i] = 1'b1;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + 26'd1;
                    end
                end
                default: begin
                    state_d[i]   = IDLE;
                    key_out_d[i] = 1'b1;
                end
            endcase
        end
    end

    assign key_out     = key_out_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random bouncing, checked against a
// run-length reference model through an expected-event queue.
module tb_key_debounce;

    localparam int CNT_DEB  = 4;
    localparam int CNT_LONG = 16;
    localparam int W        = 24;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [1:0] key_in    = 2'b11;
    logic [1:0] key_out, key_press, key_release, key_long;

    key_debounce #(
        .CNT_DEB (26'(CNT_DEB)),
        .CNT_LONG(26'(CNT_LONG))
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_in     (key_in),
        .key_out    (key_out),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    // clock / reset
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // expected event record: {cycle[15:0], key_out, press, release, long}
    logic [W-1:0] exp_q[$];

    // reference model: a key's level flips once the synchronised pin has disagreed with it
    // for CNT_DEB+1 consecutive samples; long fires on the CNT_LONG-th clean held sample.
    logic [1:0] m_s1, m_s2, m_level, m_prev;
    int         m_run  [2];
    int         m_held [2];
    bit         m_done [2];

    task automatic model_reset();
        m_s1 = 2'b11;
        m_s2 = 2'b11;
        m_level = 2'b11;
        m_prev = 2'b11;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0;
            m_held[i] = 0;
            m_done[i] = 0;
        end
    endtask

    task automatic model_step(input logic [1:0] k);
        logic [1:0] x, pr, rl, lg;
        bit clean;
        x = m_s2;
        m_s2 = m_s1;
        m_s1 = k;
        pr = 2'b00;
        rl = 2'b00;
        lg = 2'b00;
        for (int i = 0; i < 2; i++) begin
            clean = (m_level[i] == 1'b0) && (m_run[i] == 0) && (x[i] == 1'b0);
            if (x[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == CNT_DEB + 1) begin
                    m_level[i] = x[i];
                    m_run[i] = 0;
                    if (x[i] == 1'b0) begin
                        pr[i] = 1'b1;
                        m_held[i] = 0;
                        m_done[i] = 0;
                    end else begin
                        rl[i] = 1'b1;
                    end
                end
            end else begin
                m_run[i] = 0;
            end
            if (clean && !m_done[i]) begin
                m_held[i]++;
                if (m_held[i] == CNT_LONG) begin
                    lg[i] = 1'b1;
                    m_done[i] = 1;
                end
            end
        end
        if ((pr | rl | lg) != 2'b00 || m_level != m_prev)
            exp_q.push_back({16'(cyc), m_level, pr, rl, lg});
        m_prev = m_level;
    endtask

    // driver
    task automatic tick(input logic [1:0] k, input logic rst_n);
        @(negedge sys_clk);
        key_in = k;
        sys_rst_n = rst_n;
        if (!rst_n) begin
            #1;
            checks++;
            if (key_out !== 2'b11 || key_press !== 2'b00 || key_release !== 2'b00 || key_long !== 2'b00) begin
                errors++;
                $display("FAIL async_reset t=%0t: out=%b press=%b rel=%b long=%b, required out=11 pulses=00",
                         $time, key_out, key_press, key_release, key_long);
            end
        end
        @(posedge sys_clk);
        cyc++;
        if (!rst_n) model_reset();
        else model_step(k);
    endtask

    task automatic hold(input logic [1:0] k, input int n);
        for (int i = 0; i < n; i++) tick(k, 1'b1);
    endtask

    // monitor / scoreboard
    logic [1:0]   mon_prev = 2'b11;
    logic [W-1:0] got, want;

    always @(posedge sys_clk) begin
        #1;
        if (!sys_rst_n) begin
            checks++;
            if (key_out !== 2'b11 || (key_press | key_release | key_long) !== 2'b00) begin
                errors++;
                $display("FAIL reset_state cyc=%0d: out=%b press=%b rel=%b long=%b, required out=11 pulses=00",
                         cyc, key_out, key_press, key_release, key_long);
            end
            mon_prev = 2'b11;
        end else if ((key_press | key_release | key_long) !== 2'b00 || key_out !== mon_prev) begin
            got = {16'(cyc), key_out, key_press, key_release, key_long};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d: out=%b press=%b rel=%b long=%b, required no event",
                         cyc, key_out, key_press, key_release, key_long);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL event cyc=%0d: got cyc=%0d out=%b press=%b rel=%b long=%b, required cyc=%0d out=%b press=%b rel=%b long=%b",
                             cyc, got[23:8], got[7:6], got[5:4], got[3:2], got[1:0],
                             want[23:8], want[7:6], want[5:4], want[3:2], want[1:0]);
                end
            end
            mon_prev = key_out;
        end
    end

    initial begin
        int len;
        logic [1:0] k;
        model_reset();

        // reset, then idle
        for (int i = 0; i < 3; i++) tick(2'b11, 1'b0);
        hold(2'b11, 50);

        // key 0 long hold, then release
        hold(2'b10, 40);
        hold(2'b11, 12);

        // key 1 bounce shorter than the window
        hold(2'b01, 3);
        hold(2'b11, 1);
        hold(2'b01, 2);
        hold(2'b11, 10);

        // both keys together
        hold(2'b00, 12);
        hold(2'b11, 12);

        // key 0 held with a release bounce mid long-press count
        hold(2'b10, 17);
        hold(2'b11, 2);
        hold(2'b10, 25);
        hold(2'b11, 12);

        // reset while key 0 is pressed, key held through reset release
        hold(2'b10, 15);
        for (int i = 0; i < 3; i++) tick(2'b10, 1'b0);
        hold(2'b10, 12);
        hold(2'b11, 12);

        // random bouncing with occasional long holds
        for (int s = 0; s < 80; s++) begin
            k = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 8);
            hold(k, len);
        end
        hold(2'b11, 30);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: %0d expected events never seen, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
